// File: rtl/instr_mem_pkg.sv
// Shared instruction-memory constants and the loader state encoding.
// The read-side ROM sizes itself from IMEM_DEPTH as well.
package instr_mem_pkg;

    localparam int unsigned IMEM_DEPTH = 87;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } loader_state_e;

endpackage

// File: rtl/word_packer.sv
// Little-endian byte-to-word packer: first byte lands in bits [7:0].
// A final byte zero-fills the bytes above it and restarts the index.
module word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    input  logic        last_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (accept_i) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_i;
            if (last_i) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (b > 32'(idx_q)) word_d[8*b +: 8] = '0;
                end
                idx_d = '0;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word_o      = word_q;
    assign word_full_o = accept_i & ((idx_q == 2'd3) | last_i);

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a byte stream into instruction memory one packed word at a time,
// holding the CPU in reset until the program is in place.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = IMEM_DEPTH,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] word_cnt
);

    loader_state_e     state_q;
    logic              in_ready_q, wr_en_q, busy_q, done_q, err_q, last_q;
    logic [ADDR_W-1:0] wr_addr_q, word_cnt_q;
    logic              accept, load_start, at_top, word_full;
    logic [31:0]       word;

    assign accept     = in_valid & in_ready_q;
    assign load_start = start & ((state_q == IDLE) | (state_q == DONE));
    assign at_top     = (wr_addr_q == ADDR_W'(DEPTH - 1));

    word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (load_start),
        .accept_i   (accept),
        .byte_i     (in_data),
        .last_i     (in_last),
        .word_o     (word),
        .word_full_o(word_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            last_q     <= 1'b0;
            wr_addr_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (load_start) begin
                        state_q    <= RECV;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        last_q     <= 1'b0;
                        wr_addr_q  <= '0;
                        word_cnt_q <= '0;
                    end else if (state_q == DONE && in_valid && !last_q) begin
                        // Host still streaming after memory filled: bytes are lost.
                        err_q <= 1'b1;
                    end
                end
                RECV: begin
                    if (start) err_q <= 1'b1;
                    if (word_full) begin
                        state_q    <= WRITE;
                        in_ready_q <= 1'b0;
                        wr_en_q    <= 1'b1;
                        last_q     <= in_last;
                    end
                end
                WRITE: begin
                    if (start) err_q <= 1'b1;
                    wr_en_q    <= 1'b0;
                    word_cnt_q <= word_cnt_q + ADDR_W'(1);
                    if (last_q || at_top) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= RECV;
                        in_ready_q <= 1'b1;
                        wr_addr_q  <= wr_addr_q + ADDR_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = word;
    assign busy     = busy_q;
    assign cpu_hold = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader; expected words come from a plain
// little-endian packing model over the byte list sent.
module tb_instr_mem_loader;

    localparam int DEPTH  = 87;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset, start, in_valid, in_last;
    logic [7:0]        in_data;
    logic              in_ready, wr_en, cpu_hold, busy, done, err;
    logic [ADDR_W-1:0] wr_addr, word_cnt;
    logic [31:0]       wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  stim_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    always #5 clk = ~clk;

    instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_last (in_last),
        .in_ready(in_ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .cpu_hold(cpu_hold),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .word_cnt(word_cnt)
    );

    // Write monitor: one entry per cycle with wr_en high.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
    end

    function automatic logic [31:0] exp_word(input int w);
        logic [31:0] v = '0;
        for (int k = 0; k < 4; k++)
            if (w * 4 + k < stim_q.size()) v[8*k +: 8] = stim_q[w * 4 + k];
        return v;
    endfunction

    function automatic int exp_words();
        int n = (stim_q.size() + 3) / 4;
        return (n > DEPTH) ? DEPTH : n;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic fill_random(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
    endtask

    task automatic drive_stream(input bit with_last, input int gap_pct);
        int i = 0;
        int guard = 0;
        bit xfer;
        while (i < stim_q.size()) begin
            @(negedge clk);
            if (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0; in_last = 1'b0; in_data = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = stim_q[i];
                in_last  = with_last && (i == stim_q.size() - 1);
            end
            xfer = in_valid && in_ready;
            @(posedge clk);
            if (xfer) i++;
            guard++;
            if (guard > 5000) begin
                n_checks++; n_fail++;
                $display("FAIL stream_timeout: accepted %0d bytes, required %0d", i, stim_q.size());
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            if (done === 1'b1) return;
            @(negedge clk);
        end
        n_checks++; n_fail++;
        $display("FAIL done_timeout: done=%b after 400 cycles, required 1", done);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({in_ready, wr_en, cpu_hold, busy, done, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {in_ready, wr_en, cpu_hold, busy, done, err});
        end
        n_checks++;
        if (wr_addr !== '0 || wr_data !== '0 || word_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: addr=%0h data=%0h cnt=%0d, required 0", wr_addr, wr_data, word_cnt);
        end
    endtask

    task automatic test_two_words();
        do_reset();
        stim_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        pulse_start();
        drive_stream(1'b1, 0);
        wait_done();
        n_checks++;
        if (wa_q.size() != 2 || wa_q[0] !== 32'd0 || wd_q[0] !== 32'h0000_0013) begin
            n_fail++;
            $display("FAIL two_words_w0: n=%0d addr=%0d data=%h, required n=2 addr=0 data=00000013",
                     wa_q.size(), wa_q[0], wd_q[0]);
        end
        n_checks++;
        if (wa_q[1] !== 32'd1 || wd_q[1] !== 32'h0010_0093) begin
            n_fail++;
            $display("FAIL two_words_w1: addr=%0d data=%h, required addr=1 data=00100093", wa_q[1], wd_q[1]);
        end
        n_checks++;
        if (done !== 1'b1 || word_cnt !== 32'd2 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL two_words_status: done=%b cnt=%0d hold=%b busy=%b, required 1 2 0 0",
                     done, word_cnt, cpu_hold, busy);
        end
    endtask

    task automatic test_random_gaps();
        do_reset();
        fill_random(12);
        pulse_start();
        drive_stream(1'b1, 45);
        wait_done();
        n_checks++;
        if (wa_q.size() != 3) begin
            n_fail++;
            $display("FAIL gaps_count: %0d writes, required 3", wa_q.size());
        end
        for (int w = 0; w < 3; w++) begin
            n_checks++;
            if (wa_q[w] !== 32'(w) || wd_q[w] !== exp_word(w)) begin
                n_fail++;
                $display("FAIL gaps_word%0d: addr=%0d data=%h, required addr=%0d data=%h",
                         w, wa_q[w], wd_q[w], w, exp_word(w));
            end
        end
    endtask

    task automatic test_capacity();
        int bad = 0;
        do_reset();
        fill_random(DEPTH * 4);
        pulse_start();
        drive_stream(1'b0, 0);
        wait_done();
        n_checks++;
        if (wa_q.size() != exp_words() || wa_q[DEPTH-1] !== 32'(DEPTH - 1)) begin
            n_fail++;
            $display("FAIL cap_count: %0d writes last_addr=%0d, required %0d and %0d",
                     wa_q.size(), wa_q[DEPTH-1], DEPTH, DEPTH - 1);
        end
        for (int w = 0; w < DEPTH; w++)
            if (wa_q[w] !== 32'(w) || wd_q[w] !== exp_word(w)) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL cap_data: %0d words differ, required 0", bad);
        end
        n_checks++;
        if (done !== 1'b1 || err !== 1'b0 || word_cnt !== 32'(DEPTH)) begin
            n_fail++;
            $display("FAIL cap_status: done=%b err=%b cnt=%0d, required 1 0 %0d", done, err, word_cnt, DEPTH);
        end
        in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || wa_q.size() != DEPTH || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cap_overflow: err=%b writes=%0d ready=%b, required 1 %0d 0",
                     err, wa_q.size(), in_ready, DEPTH);
        end
    endtask

    task automatic test_reload();
        do_reset();
        stim_q = '{8'hAA, 8'hBB};
        pulse_start();
        drive_stream(1'b1, 0);
        wait_done();
        n_checks++;
        if (wa_q.size() != 1 || wa_q[0] !== 32'd0 || wd_q[0] !== 32'h0000_BBAA) begin
            n_fail++;
            $display("FAIL short_word: n=%0d addr=%0d data=%h, required n=1 addr=0 data=0000bbaa",
                     wa_q.size(), wa_q[0], wd_q[0]);
        end
        wa_q.delete(); wd_q.delete();
        pulse_start();
        n_checks++;
        if (done !== 1'b0 || word_cnt !== '0 || busy !== 1'b1 || cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_status: done=%b cnt=%0d busy=%b hold=%b, required 0 0 1 1",
                     done, word_cnt, busy, cpu_hold);
        end
        fill_random(3);
        drive_stream(1'b1, 20);
        wait_done();
        n_checks++;
        if (wa_q.size() != 1 || wa_q[0] !== 32'd0 || wd_q[0] !== exp_word(0)) begin
            n_fail++;
            $display("FAIL restart_word: n=%0d addr=%0d data=%h, required n=1 addr=0 data=%h",
                     wa_q.size(), wa_q[0], wd_q[0], exp_word(0));
        end
    endtask

    task automatic test_reset_midload();
        do_reset();
        fill_random(6);
        pulse_start();
        drive_stream(1'b0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({in_ready, wr_en, cpu_hold, busy, done, err} !== 6'b0 ||
            wr_addr !== '0 || wr_data !== '0 || word_cnt !== '0) begin
            n_fail++;
            $display("FAIL midload_reset: flags=%b addr=%0d data=%h cnt=%0d, required all zero",
                     {in_ready, wr_en, cpu_hold, busy, done, err}, wr_addr, wr_data, word_cnt);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (wa_q.size() != 1 || wa_q[0] !== 32'd0 || wd_q[0] !== exp_word(0)) begin
            n_fail++;
            $display("FAIL midload_writes: n=%0d addr=%0d data=%h, required n=1 addr=0 data=%h",
                     wa_q.size(), wa_q[0], wd_q[0], exp_word(0));
        end
    endtask

    task automatic test_start_while_busy();
        do_reset();
        fill_random(8);
        pulse_start();
        fork
            drive_stream(1'b1, 0);
            begin
                repeat (3) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        wait_done();
        n_checks++;
        if (err !== 1'b1 || done !== 1'b1 || word_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL busy_start_status: err=%b done=%b cnt=%0d, required 1 1 2", err, done, word_cnt);
        end
        n_checks++;
        if (wa_q.size() != 2 || wa_q[0] !== 32'd0 || wa_q[1] !== 32'd1 ||
            wd_q[0] !== exp_word(0) || wd_q[1] !== exp_word(1)) begin
            n_fail++;
            $display("FAIL busy_start_writes: n=%0d a0=%0d a1=%0d d0=%h d1=%h, required 2 0 1 %h %h",
                     wa_q.size(), wa_q[0], wa_q[1], wd_q[0], wd_q[1], exp_word(0), exp_word(1));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        test_reset();
        test_two_words();
        test_random_gaps();
        test_capacity();
        test_reload();
        test_reset_midload();
        test_start_while_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running at 2 ms, required finish");
        $fatal(1);
    end

endmodule
